// File: rtl/requester_node.sv
// Requester node: turns one local command at a time into a request flit toward
// a complete node, then waits for the response flit or a timeout before completing locally.
module requester_node #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int REQ_FLIT_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8,
    parameter int RSP_FLIT_WIDTH = 2 + DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    input  logic                      cmd_nse,
    output logic                      rn_valid,
    input  logic                      cn_ready,
    output logic [REQ_FLIT_WIDTH-1:0] icn_rxreq,
    input  logic [RSP_FLIT_WIDTH-1:0] icn_txrsp,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                    state_q,   state_d;
    logic [REQ_FLIT_WIDTH-1:0] flit_q,    flit_d;
    logic [CNT_WIDTH-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0]     rdata_q,   rdata_d;
    logic                      err_q,     err_d;
    logic                      timeout_q, timeout_d;

    logic                      cmd_accept;
    logic [DATA_WIDTH-1:0]     wdata_field;
    logic [STRB_WIDTH-1:0]     strb_field;
    logic [REQ_FLIT_WIDTH-1:0] cmd_flit;

    logic                      rsp_rvalid;
    logic                      rsp_slverr;
    logic [DATA_WIDTH-1:0]     rsp_data;

    // Reads carry no payload, so their data and strobe fields are forced to zero.
    assign wdata_field = cmd_write ? cmd_wdata : {DATA_WIDTH{1'b0}};
    assign strb_field  = cmd_write ? cmd_strb  : {STRB_WIDTH{1'b0}};
    assign cmd_flit    = {cmd_write, cmd_prot, cmd_nse, 3'b000, cmd_addr, wdata_field, strb_field};

    assign rsp_rvalid  = icn_txrsp[RSP_FLIT_WIDTH-1];
    assign rsp_slverr  = icn_txrsp[RSP_FLIT_WIDTH-2];
    assign rsp_data    = icn_txrsp[DATA_WIDTH-1:0];

    assign cmd_ready   = (state_q == ST_IDLE) && !preset_n;
    assign cmd_accept  = cmd_valid && cmd_ready;

    assign rn_valid    = (state_q == ST_REQ);
    assign rsp_valid   = (state_q == ST_RESP);
    assign icn_rxreq   = flit_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the case infers a latch.
        state_d   = state_q;
        flit_d    = flit_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    flit_d  = cmd_flit;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (cn_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A response arriving on the last counted cycle still beats the timeout.
                if (rsp_rvalid) begin
                    rdata_d   = rsp_data;
                    err_d     = rsp_slverr;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset is active-high despite the name; asserting it aborts any transaction in flight.
    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            state_q   <= ST_IDLE;
            flit_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of its peers.
            state_q   <= state_d;
            flit_q    <= flit_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
